// File: rtl/add_16bit_seq.sv
// -----------------------------------------------------------------------------
// add_16bit_seq
//
// Sequential 16-bit adder. It adds one DIGIT_W-bit slice per clock and ripples
// the slice carry from one cycle into the next. Operands come in and results go
// out through valid/ready handshakes. The result stays held until the consumer
// accepts it.
//
// Parameters
//   DIGIT_W   slice width added per cycle. Legal values: 1, 2, 4, 8, 16.
//             Latency from accept to out_valid is 16/DIGIT_W cycles.
//
// Ports
//   clk       clock. All state changes on the rising edge.
//   rst       synchronous, active-high reset. It has priority over any handshake.
//   in_valid  a/b are valid. Sampled only while in_ready is high.
//   in_ready  high only in IDLE.
//   a, b      16-bit operands, unsigned or two's complement.
//   out_valid high only in DONE. sum/carry/overflow are stable while it is high.
//   out_ready the consumer takes the result. DONE -> IDLE on the next edge.
//   sum       a+b modulo 2^16. Saturated on signed overflow when ADD_SAT_EN
//             is defined.
//   carry     unsigned carry out of bit 15. Saturation does not change it.
//   overflow  signed overflow of a+b. Saturation does not change it.
//
// Build option
//   ADD_SAT_EN  when defined, sum is clamped to 0x7FFF / 0x8000 on signed
//               overflow. Without it there is no saturation logic at all.
// -----------------------------------------------------------------------------
module add_16bit_seq #(
    parameter int DIGIT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        carry,
    output logic        overflow
);

    localparam int NDIG  = 16 / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operands and result are held as arrays of slices. The digit counter
    // then selects a slice directly, with no variable bit arithmetic.
    logic [NDIG-1:0][DIGIT_W-1:0] a_r, b_r, sum_r;
    logic [CNT_W-1:0]             cnt;
    logic                         cin;
    logic                         carry_r;
    logic                         ovf_r;

    logic [DIGIT_W:0]             slice;
    logic                         last;
    logic                         a_sign, b_sign;
    logic                         ovf_raw;

    // One ripple step. The top bit is the carry into the next slice.
    assign slice = {1'b0, a_r[cnt]} + {1'b0, b_r[cnt]} + {{DIGIT_W{1'b0}}, cin};
    assign last  = (cnt == LAST);

    assign a_sign = a_r[NDIG-1][DIGIT_W-1];
    assign b_sign = b_r[NDIG-1][DIGIT_W-1];

    // Only meaningful on the last slice. There, slice[DIGIT_W-1] is raw bit 15.
    assign ovf_raw = (a_sign == b_sign) && (slice[DIGIT_W-1] != a_sign);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Going back to IDLE first means a new accept cannot happen
                // on the same edge that releases the result.
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cnt     <= '0;
            cin     <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        sum_r   <= '0;
                        cnt     <= '0;
                        cin     <= 1'b0;
                        carry_r <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                CALC: begin
                    sum_r[cnt] <= slice[DIGIT_W-1:0];
                    cin        <= slice[DIGIT_W];
                    if (last) begin
                        cnt     <= '0;
                        carry_r <= slice[DIGIT_W];
                        ovf_r   <= ovf_raw;
`ifdef ADD_SAT_EN
                        // Clamp toward the sign of the operands. The flags
                        // above still report the raw result.
                        if (ovf_raw) sum_r <= a_sign ? 16'h8000 : 16'h7FFF;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;  // DONE: hold the result
            endcase
        end
    end

    assign sum      = sum_r;
    assign carry    = carry_r;
    assign overflow = ovf_r;

endmodule

// File: doc/add_16bit_seq.md
ADD_16BIT_SEQ -- requirements
Module: add_16bit_seq

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4, giving the adder slice width per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operands a and b are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 SHALL have port a, input, 16 bits: augend, two's complement or unsigned.
REQ-007 SHALL have port b, input, 16 bits: addend, two's complement or unsigned.
REQ-008 SHALL have port out_valid, output, 1 bit: the result outputs are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port sum, output, 16 bits: a+b modulo 2^16 (saturated when the saturation feature is compiled in).
REQ-011 SHALL have port carry, output, 1 bit: unsigned carry out of bit 15.
REQ-012 SHALL have port overflow, output, 1 bit: signed overflow of a+b.

Function
REQ-013 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-014 SHALL assert in_ready only in IDLE and out_valid only in DONE.
REQ-015 SHALL register a and b and clear the internal carry when in_valid and in_ready are both high at a clock edge, then move to CALC.
REQ-016 SHALL add one DIGIT_W slice per cycle in CALC, starting at the least significant slice, as a ripple carry: each slice uses the previous slice's carry-out as its carry-in.
REQ-017 SHALL hold a digit counter that runs 0 to 16/DIGIT_W-1 and move to DONE on the edge that computes the last slice.
REQ-018 SHALL assert out_valid exactly 16/DIGIT_W cycles after the accepting edge (4 cycles at the default DIGIT_W).
REQ-019 SHALL hold sum, carry and overflow stable while in DONE.
REQ-020 SHALL compute overflow = (a[15] == b[15]) and (raw sum[15] != a[15]).
REQ-021 SHALL set carry to the carry out of bit 15, unaffected by saturation.
REQ-022 SHALL return from DONE to IDLE on the edge where out_valid and out_ready are both high; there is no same-cycle accept of new operands; the earliest new accept is one cycle later.
REQ-023 SHALL keep the result in DONE indefinitely while out_ready is low, with no loss or corruption.
REQ-024 SHALL ignore in_valid in CALC and DONE, and SHALL leave a and b free to change outside the accepting edge.

Reset
REQ-025 SHALL, when rst is high at a clock edge, go to IDLE from any state, aborting any operation in progress, and clear the digit counter and internal carry.
REQ-026 SHALL drive in_ready=1, out_valid=0, sum=0x0000, carry=0 and overflow=0 in the cycle after the reset edge.
REQ-027 SHALL give rst priority over any handshake in the same cycle.

Configuration
REQ-028 SHALL, when macro ADD_SAT_EN is defined, replace sum with 0x7FFF when overflow=1 and a[15]=0, and with 0x8000 when overflow=1 and a[15]=1; overflow and carry still report the raw condition.
REQ-029 SHALL, when ADD_SAT_EN is not defined, output the wrapped modulo-2^16 sum, with no saturation logic present.

Verification
REQ-030 SHALL cover: a=0x1234, b=0x0FED, DIGIT_W=4 -> out_valid 4 cycles after accept, sum=0x2221, carry=0, overflow=0.
REQ-031 SHALL cover: a=0x7FFF, b=0x0001 -> overflow=1, carry=0, sum=0x8000 (0x7FFF with ADD_SAT_EN).
REQ-032 SHALL cover: a=0x8000, b=0x8000 -> carry=1, overflow=1, sum=0x0000 (0x8000 with ADD_SAT_EN); and a=0xFFFF, b=0x0001 -> sum=0x0000, carry=1, overflow=0.
REQ-033 SHALL cover: out_ready held low 10 cycles in DONE -> out_valid and sum stable, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-034 SHALL cover: rst pulsed in the second CALC cycle -> next cycle in_ready=1, out_valid=0, all outputs zero; a new operation then completes correctly.
REQ-035 SHALL cover: DIGIT_W=1 and DIGIT_W=16 with 1000 random operand pairs -> latency 16 and 1 cycles respectively, and every result matches a reference a+b model.
